// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, threshold flags, error pulses and optional FWFT output
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, overflow_q, underflow_q;
    logic                  rd_ok, wr_ok;

    assign empty        = count_q == '0;
    assign full         = count_q == CW'(DEPTH);
    assign almost_full  = count_q >= CW'(AF_LEVEL);
    assign almost_empty = count_q <= CW'(AE_LEVEL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign dout         = FWFT != 0 ? (empty ? '0 : mem_q[rd_ptr_q]) : dout_q;
    assign dout_valid   = FWFT != 0 ? !empty : dout_valid_q;

    // Accept decisions and next-state; a read frees a slot so a full FIFO can still take a write
    always_comb begin
        rd_ok    = en && rd && !empty;
        wr_ok    = en && wr && (!full || rd_ok);
        wr_ptr_d = wr_ok ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = (wr_ok && !rd_ok) ? count_q + 1'b1 :
                   (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;
        dout_d   = rd_ok ? mem_q[rd_ptr_q] : dout_q;
    end

    // Control state with synchronous active-low reset taking priority over enable
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= rd_ok;
            overflow_q   <= en && wr && !wr_ok;
            underflow_q  <= en && rd && !rd_ok;
        end
    end

    // Storage array is never cleared; writes are blocked while reset is asserted
    always_ff @(posedge clk) begin
        if (rst && wr_ok) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for a DEPTH=5 standard FIFO and a DEPTH=8 FWFT FIFO
module tb_sync_fifo_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en5, wr5, rd5, en8, wr8, rd8;
    logic [31:0] din5, dout5, din8, dout8;
    logic        dv5, full5, empty5, af5, ae5, ov5, uf5;
    logic        dv8, full8, empty8, af8, ae8, ov8, uf8;
    logic [2:0]  cnt5;
    logic [3:0]  cnt8;

    int          errs = 0;
    int          checks = 0;
    logic [31:0] q5[$];
    logic [31:0] q8[$];
    logic [31:0] last5 = '0;

    sync_fifo_param #(.DATA_WIDTH(32), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(0)) u5 (
        .clk(clk), .rst(rst), .en(en5), .wr(wr5), .din(din5), .rd(rd5),
        .dout(dout5), .dout_valid(dv5), .full(full5), .empty(empty5),
        .almost_full(af5), .almost_empty(ae5), .count(cnt5),
        .overflow(ov5), .underflow(uf5));

    sync_fifo_param #(.DATA_WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u8 (
        .clk(clk), .rst(rst), .en(en8), .wr(wr8), .din(din8), .rd(rd8),
        .dout(dout8), .dout_valid(dv8), .full(full8), .empty(empty8),
        .almost_full(af8), .almost_empty(ae8), .count(cnt8),
        .overflow(ov8), .underflow(uf8));

    // Single comparison point: counts every check and reports any mismatch
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle on the standard-mode FIFO; expected data comes from the queue
    task automatic step5(input logic w, input logic r, input logic [31:0] d);
        logic racc, wacc;
        wr5 = w; rd5 = r; din5 = d;
        racc = r && q5.size() > 0;
        wacc = w && (q5.size() < 5 || racc);
        @(posedge clk); #1;
        if (wacc) q5.push_back(d);
        if (racc) last5 = q5.pop_front();
        chk("dv5",   32'(dv5), 32'(racc));
        chk("dout5", dout5, last5);
        chk("ovf5",  32'(ov5), 32'(w && !wacc));
        chk("udf5",  32'(uf5), 32'(r && !racc));
        chk("cnt5",  32'(cnt5), q5.size());
        chk("full5", 32'(full5), 32'(q5.size() == 5));
        chk("empty5", 32'(empty5), 32'(q5.size() == 0));
        chk("af5",   32'(af5), 32'(q5.size() >= 3));
        chk("ae5",   32'(ae5), 32'(q5.size() <= 2));
        wr5 = 1'b0; rd5 = 1'b0;
    endtask

    // One cycle on the FWFT FIFO; head of queue must be presented on dout
    task automatic step8(input logic w, input logic r, input logic [31:0] d, input logic e);
        logic racc, wacc;
        en8 = e; wr8 = w; rd8 = r; din8 = d;
        racc = e && r && q8.size() > 0;
        wacc = e && w && (q8.size() < 8 || racc);
        @(posedge clk); #1;
        if (racc) void'(q8.pop_front());
        if (wacc) q8.push_back(d);
        chk("dout8", dout8, q8.size() > 0 ? q8[0] : 32'h0);
        chk("dv8",   32'(dv8), 32'(q8.size() > 0));
        chk("ovf8",  32'(ov8), 32'(e && w && !wacc));
        chk("udf8",  32'(uf8), 32'(e && r && !racc));
        chk("cnt8",  32'(cnt8), q8.size());
        chk("full8", 32'(full8), 32'(q8.size() == 8));
        chk("empty8", 32'(empty8), 32'(q8.size() == 0));
        chk("af8",   32'(af8), 32'(q8.size() >= 6));
        chk("ae8",   32'(ae8), 32'(q8.size() <= 2));
        en8 = 1'b1; wr8 = 1'b0; rd8 = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en5 = 1'b1; en8 = 1'b1;
        wr5 = 1'b0; rd5 = 1'b0; din5 = '0;
        wr8 = 1'b0; rd8 = 1'b0; din8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt5", 32'(cnt5), 0);
        chk("rst_empty5", 32'(empty5), 1);
        chk("rst_ae5", 32'(ae5), 1);
        chk("rst_full5", 32'(full5), 0);
        chk("rst_af5", 32'(af5), 0);
        chk("rst_dout5", dout5, 0);
        chk("rst_dv5", 32'(dv5), 0);
        chk("rst_ov5", 32'(ov5), 0);
        chk("rst_uf5", 32'(uf5), 0);
        chk("rst_cnt8", 32'(cnt8), 0);
        chk("rst_dout8", dout8, 0);
        chk("rst_dv8", 32'(dv8), 0);
        rst = 1'b1;

        for (int i = 1; i <= 5; i++) step5(1'b1, 1'b0, 32'(i));
        step5(1'b1, 1'b0, 32'd6);
        for (int i = 0; i < 6; i++) step5(1'b0, 1'b1, '0);

        for (int i = 0; i < 3; i++) step5(1'b1, 1'b0, 32'(16 + i));
        for (int i = 0; i < 3; i++) step5(1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) step5(1'b1, 1'b0, 32'(32 + i));
        for (int i = 0; i < 4; i++) step5(1'b0, 1'b1, '0);

        for (int i = 0; i < 5; i++) step5(1'b1, 1'b0, 32'(48 + i));
        step5(1'b1, 1'b1, 32'd99);
        for (int i = 0; i < 5; i++) step5(1'b0, 1'b1, '0);
        step5(1'b1, 1'b1, 32'd77);
        step5(1'b0, 1'b1, '0);

        for (int i = 0; i < 60; i++)
            step5(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

        step8(1'b1, 1'b0, 32'hA5, 1'b1);
        step8(1'b0, 1'b1, '0, 1'b1);
        step8(1'b0, 1'b1, '0, 1'b1);
        for (int i = 1; i <= 9; i++) step8(1'b1, 1'b0, 32'(256 + i), 1'b1);
        for (int i = 0; i < 3; i++) step8(1'b1, 1'b1, 32'(512 + i), 1'b1);
        for (int i = 0; i < 5; i++) step8(1'b0, 1'b1, '0, 1'b1);
        for (int i = 0; i < 3; i++) step8(1'b1, 1'b1, 32'(768 + i), 1'b0);
        for (int i = 0; i < 40; i++)
            step8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));

        step8(1'b1, 1'b0, 32'h1234, 1'b1);
        rst = 1'b0; en8 = 1'b0; wr8 = 1'b1;
        @(posedge clk); #1;
        q8.delete(); q5.delete();
        chk("rst_en0_cnt8", 32'(cnt8), 0);
        chk("rst_en0_empty8", 32'(empty8), 1);
        chk("rst_en0_dout8", dout8, 0);
        chk("rst_cnt5_end", 32'(cnt5), 0);
        rst = 1'b1; wr8 = 1'b0; en8 = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
